// File: rtl/mul_disp_ctrl_if.sv
// Handshake and display bus between the multiply/display controller and its host.
interface mul_disp_ctrl_if;
   logic        start;
   logic [7:0]  ina;
   logic [7:0]  inb;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [19:0] bcd;
   logic [6:0]  seg;
   logic [4:0]  dig_sel;

   modport master (
      output start, ina, inb,
      input  busy, done, product, bcd, seg, dig_sel
   );

   modport slave (
      input  start, ina, inb,
      output busy, done, product, bcd, seg, dig_sel
   );
endinterface

// File: rtl/mul_disp_ctrl.sv
// 8x8 shift-add multiplier, double-dabble BCD conversion and 5-digit multiplexed 7-segment scan.
// Optional leading-zero blanking is enabled by defining MUL_DISP_LZB_EN.
//
// state | meaning
// IDLE  | no result yet since reset, display dark, waiting for start
// MUL   | 8 shift-add steps, LSB of operand B first
// BCD   | load step, then 16 double-dabble iterations; commit on the last one
// SHOW  | scanning the committed result, start launches a new computation
module mul_disp_ctrl #(
   parameter int SCAN_DIV = 50000
) (
   input logic           clk,
   input logic           rst_n,
   mul_disp_ctrl_if.slave bus
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, MUL, BCD, SHOW} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] mcand_q, mcand_d;
   logic [7:0]  mplier_q, mplier_d;
   logic [35:0] dd_q, dd_d;
   logic        commit;

   logic [15:0] prod_q;
   logic [19:0] bcd_q;
   logic        done_q;
   logic        disp_en_q;
   logic [DIV_W-1:0] div_q, div_n;
   logic [2:0]  idx_q, idx_n;
   logic [6:0]  seg_q, seg_n;
   logic [4:0]  dig_q, dig_n;
   logic [19:0] bcd_n;
   logic        en_n;
   logic [3:0]  digit;
   logic        blank;

   function automatic logic [35:0] dabble(input logic [35:0] v);
      logic [35:0] t;
      t = v;
      for (int k = 0; k < 5; k++) begin
         if (t[16 + 4*k +: 4] >= 4'd5)
            t[16 + 4*k +: 4] = t[16 + 4*k +: 4] + 4'd3;
      end
      return t << 1;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         dd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         dd_q     <= dd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      dd_d     = dd_q;
      commit   = 1'b0;
      case (state_q)
         IDLE, SHOW: begin
            if (bus.start) begin
               acc_d    = '0;
               mcand_d  = {8'd0, bus.ina};
               mplier_d = bus.inb;
               cnt_d    = '0;
               state_d  = MUL;
            end
         end
         MUL: begin
            if (mplier_q[0])
               acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
               cnt_d   = '0;
               state_d = BCD;
            end
         end
         BCD: begin
            // Step 0 loads the binary product; steps 1..16 are the dabble iterations.
            if (cnt_q == 5'd0) begin
               dd_d = {20'd0, acc_q};
            end else begin
               dd_d = dabble(dd_q);
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd16) begin
               commit  = 1'b1;
               cnt_d   = '0;
               state_d = SHOW;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_n = div_q + DIV_W'(1);
      idx_n = idx_q;
      if (div_q == DIV_LAST) begin
         div_n = '0;
         idx_n = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end
      bcd_n = commit ? dd_d[35:16] : bcd_q;
      en_n  = disp_en_q | commit;
      case (idx_n)
         3'd1:    digit = bcd_n[7:4];
         3'd2:    digit = bcd_n[11:8];
         3'd3:    digit = bcd_n[15:12];
         3'd4:    digit = bcd_n[19:16];
         default: digit = bcd_n[3:0];
      endcase
`ifdef MUL_DISP_LZB_EN
      blank = (idx_n != 3'd0) && ((bcd_n >> {idx_n, 2'b00}) == 20'd0);
`else
      blank = 1'b0;
`endif
      seg_n = '0;
      dig_n = '0;
      if (en_n) begin
         dig_n = 5'b00001 << idx_n;
         seg_n = blank ? 7'b0000000 : seg_of(digit);
      end
   end

   // Scan runs from the value committed on this same edge, so display and result switch together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_q    <= '0;
         bcd_q     <= '0;
         done_q    <= 1'b0;
         disp_en_q <= 1'b0;
         div_q     <= '0;
         idx_q     <= '0;
         seg_q     <= '0;
         dig_q     <= '0;
      end else begin
         done_q    <= commit;
         disp_en_q <= en_n;
         div_q     <= div_n;
         idx_q     <= idx_n;
         seg_q     <= seg_n;
         dig_q     <= dig_n;
         bcd_q     <= bcd_n;
         if (commit)
            prod_q <= acc_q;
      end
   end

   assign bus.busy    = (state_q == MUL) || (state_q == BCD);
   assign bus.done    = done_q;
   assign bus.product = prod_q;
   assign bus.bcd     = bcd_q;
   assign bus.seg     = seg_q;
   assign bus.dig_sel = dig_q;

endmodule

// File: tb/tb_mul_disp_ctrl.sv
// Randomized bench for mul_disp_ctrl against a cycle-count reference model of result and scan.
module tb_mul_disp_ctrl;
   localparam int SD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_disp_ctrl_if bus();
   mul_disp_ctrl #(.SCAN_DIV(SD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      x = v;
      r = '0;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference: counts edges since reset and the latency of each accepted start.
   bit   m_valid = 0;
   int   m_n, m_pend, m_a, m_b, m_prod;
   logic m_done, m_en;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1;
         m_n = 0; m_pend = 0; m_prod = 0; m_done = 0; m_en = 0;
      end else begin
         m_n++;
         m_done = 0;
         if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
               m_prod = m_a * m_b;
               m_en   = 1;
               m_done = 1;
            end
         end else if (bus.start) begin
            m_a = int'(bus.ina);
            m_b = int'(bus.inb);
            m_pend = 25;
         end
      end
   end

   function automatic logic [4:0] exp_dig();
      if (!m_en) return 5'b0;
      return 5'b00001 << ((m_n / SD) % 5);
   endfunction

   function automatic logic [6:0] exp_seg();
      int idx, p;
      if (!m_en) return 7'b0;
      idx = (m_n / SD) % 5;
      p = 10 ** idx;
`ifdef MUL_DISP_LZB_EN
      if (idx > 0 && m_prod < p) return 7'b0;
`endif
      return seg7((m_prod / p) % 10);
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", 32'(bus.busy), 32'(m_pend > 0));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("product", 32'(bus.product), 32'(m_prod));
         chk("bcd", 32'(bus.bcd), 32'(to_bcd(m_prod)));
         chk("dig_sel", 32'(bus.dig_sel), 32'(exp_dig()));
         chk("seg", 32'(bus.seg), 32'(exp_seg()));
      end
   end

   logic [6:0] slot_seg [5];

   task automatic run(input logic [7:0] a, input logic [7:0] b, output int lat);
      bus.ina = a; bus.inb = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic scan_slots();
      for (int k = 0; k < 5; k++) slot_seg[k] = 7'h7f;
      for (int c = 0; c < 5*SD; c++) begin
         for (int k = 0; k < 5; k++)
            if (bus.dig_sel[k]) slot_seg[k] = bus.seg;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, dcount;
      logic [6:0] z;
      bus.start = 1'b0; bus.ina = '0; bus.inb = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 0 * 55
      run(8'd0, 8'd55, lat);
      chk("lat_0x55", lat, 25);
      chk("prod_0x55", 32'(bus.product), 0);
      chk("bcd_0x55", 32'(bus.bcd), 32'h00000);
      scan_slots();
`ifdef MUL_DISP_LZB_EN
      z = 7'b0000000;
`else
      z = 7'b0111111;
`endif
      chk("slot0_zero", 32'(slot_seg[0]), 32'b0111111);
      chk("slot1_zero", 32'(slot_seg[1]), 32'(z));
      chk("slot4_zero", 32'(slot_seg[4]), 32'(z));

      // 255 * 255
      run(8'hFF, 8'hFF, lat);
      chk("lat_ffxff", lat, 25);
      chk("model_prod_max", m_prod, 65025);
      chk("prod_max", 32'(bus.product), 65025);
      chk("bcd_max", 32'(bus.bcd), 32'h65025);
      scan_slots();
      chk("slot0_max", 32'(slot_seg[0]), 32'b1101101);
      chk("slot1_max", 32'(slot_seg[1]), 32'b1011011);
      chk("slot2_max", 32'(slot_seg[2]), 32'b0111111);
      chk("slot3_max", 32'(slot_seg[3]), 32'b1101101);
      chk("slot4_max", 32'(slot_seg[4]), 32'b1111101);

      // 12 * 10 with an ignored 3 * 3 start at cycle 10
      bus.ina = 8'd12; bus.inb = 8'd10; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = -1; dcount = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 9) begin
            bus.ina = 8'd3; bus.inb = 8'd3; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) begin
            dcount++;
            if (dcount == 1) lat = c;
         end
         @(negedge clk);
      end
      chk("lat_12x10", lat, 25);
      chk("done_count_12x10", dcount, 1);
      chk("prod_12x10", 32'(bus.product), 120);
      chk("bcd_12x10", 32'(bus.bcd), 32'h00120);
      scan_slots();
      chk("slot0_120", 32'(slot_seg[0]), 32'b0111111);
      chk("slot1_120", 32'(slot_seg[1]), 32'b1011011);
      chk("slot2_120", 32'(slot_seg[2]), 32'b0000110);
`ifdef MUL_DISP_LZB_EN
      z = 7'b0000000;
`else
      z = 7'b0111111;
`endif
      chk("slot3_120", 32'(slot_seg[3]), 32'(z));
      chk("slot4_120", 32'(slot_seg[4]), 32'(z));

      // 7 * 9 from SHOW; the per-cycle compare holds 120 until the commit edge
      run(8'd7, 8'd9, lat);
      chk("lat_7x9", lat, 25);
      chk("prod_7x9", 32'(bus.product), 63);
      chk("bcd_7x9", 32'(bus.bcd), 32'h00063);

      // Reset in the middle of MUL
      bus.ina = 8'd9; bus.inb = 8'd9; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_product", 32'(bus.product), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_dig_sel", 32'(bus.dig_sel), 0);
      chk("rst_seg", 32'(bus.seg), 0);
      run(8'd2, 8'd3, lat);
      chk("lat_2x3", lat, 25);
      chk("prod_2x3", 32'(bus.product), 6);

      // Random traffic: held starts, mid-busy starts, idle gaps, occasional reset
      for (int it = 0; it < 40; it++) begin
         int hold, gap;
         hold = int'($urandom_range(1, 60));
         for (int c = 0; c < hold; c++) begin
            bus.ina = 8'($urandom);
            bus.inb = 8'($urandom);
            bus.start = ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
         bus.start = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         gap = int'($urandom_range(0, 30));
         repeat (gap) @(negedge clk);
      end
      repeat (30) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
